mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits beside the EX-stage ALU and is launched by the controller's multiply/divide start and sign controls. It supports signed and unsigned 32×32 multiply and divide at a parametrised width. While an operation is in flight it asserts `busy`, and the hazard unit stalls any mfhi/mflo/mthi/mtlo or new mult/div until `busy` deasserts.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits; must be ≥ 4 and even.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start_mult` input 1: launch multiply when idle.
- `start_div` input 1: launch divide when idle.
- `mult_sign` input 1: 1 = signed operands (mult/div), 0 = unsigned (multu/divu); sampled with start.
- `srca` input WIDTH: multiplicand / dividend; also the data source for mthi/mtlo.
- `srcb` input WIDTH: multiplier / divisor.
- `mthi` input 1: write `srca` to HI when idle.
- `mtlo` input 1: write `srca` to LO when idle.
- `busy` output 1: operation in flight.
- `done` output 1: one-cycle pulse when HI/LO receive a result.
- `hi` output WIDTH: HI register (product upper half / remainder).
- `lo` output WIDTH: LO register (product lower half / quotient).

## Operation
- States:
  - IDLE: waiting for a launch.
  - MUL: one shift-add iteration per cycle.
  - DIV: one restoring-subtract iteration per cycle.
  - FIX: sign correction and HI/LO writeback.
- Launch from IDLE:
  - `start_mult` → MUL; `start_div` → DIV.
  - Both high → MUL wins; `start_div` is ignored.
  - Operand magnitudes are captured and `mult_sign` is latched.
  - Signed mode: negative operands are two's-complement negated to magnitudes. The magnitude of the most-negative value is 2^(WIDTH-1) as unsigned.
  - The sign of the result and the sign of the dividend are latched.
  - The iteration counter loads `WIDTH`.
- MUL / DIV: one iteration per cycle, counter decrements; at counter = 1 the next state is FIX.
- FIX:
  - Multiply: the 2·WIDTH product is negated if signed and the operand signs differ. Upper half → HI, lower half → LO.
  - Divide: the quotient is negated if signed and the operand signs differ. The remainder is negated if signed and the dividend is negative. Remainder → HI, quotient → LO.
  - `done` pulses; return to IDLE.
- Divide by zero (`srcb` = 0 at launch):
  - Runs the full latency.
  - Result is HI = `srca` as captured (unmodified), LO = all ones.
  - No sign correction.
- Signed most-negative ÷ −1: LO = 0x8000…0 (wraps), HI = 0. This falls out of the magnitude arithmetic and needs no special case.
- `start_*` while not IDLE: ignored; the in-flight operation is unaffected.
- mthi/mtlo:
  - Honoured only in IDLE with no start that cycle; start takes priority.
  - mthi and mtlo together write both HI and LO.
  - While busy they are ignored; preventing them there is the hazard unit's job.
- `busy` is high in MUL, DIV and FIX, registered from state.
- Reset (any time, including mid-operation): state IDLE, counter 0, HI = 0, LO = 0, `busy` = 0, `done` = 0. Any in-flight result is discarded.

## Timing
- Launch sampled at edge k; `busy` is high from after edge k until edge k+WIDTH+1.
- HI/LO are updated, `done` rises, and `busy` falls at edge k+WIDTH+1.
- Latency is WIDTH+1 cycles (33 for WIDTH = 32), identical for mult, div, signed, unsigned and divide-by-zero.
- `done` is high for exactly one cycle.
- A new start is accepted in the same cycle `done` is high (state is IDLE), giving back-to-back throughput of one operation per WIDTH+1 cycles.
- `hi`/`lo` hold their previous values throughout an operation and change only at FIX or at an idle mthi/mtlo edge.
- mthi/mtlo write at the sampling edge; new values are visible in the next cycle.

## Test plan
- Signed multiply, `mult_sign` = 1: srca 0xFFFFFFFE × srcb 3 → at edge k+33, HI 0xFFFFFFFF, LO 0xFFFFFFFA, `done` pulses once, `busy` high for 33 cycles.
- Unsigned multiply, `mult_sign` = 0: 0xFFFFFFFF × 0xFFFFFFFF → HI 0xFFFFFFFE, LO 0x00000001.
- Divide:
  - Signed −7 ÷ 2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF.
  - Unsigned 7 ÷ 2 → LO 3, HI 1.
  - Signed 0x80000000 ÷ 0xFFFFFFFF → LO 0x80000000, HI 0.
- Divide by zero: srca 0x00001234, srcb 0 → HI 0x00001234, LO 0xFFFFFFFF after 33 cycles.
- Contention:
  - `start_mult` and `start_div` together → multiply result.
  - `start_div` pulsed at cycle 5 of a multiply → ignored, multiply result intact.
  - mthi with srca 0xAAAA5555 while busy → HI unchanged.
  - Same mthi while idle → HI 0xAAAA5555 next cycle.
- Reset: assert `reset` asynchronously at cycle 10 of a divide → immediately `busy` 0, `done` 0, HI 0, LO 0. After release a new multiply 3 × 4 gives LO 12, HI 0 with normal latency.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes, then one sign-fix cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic               is_mul, res_neg, dvd_neg, div_zero;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, trial, diff;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   rem, quo;

  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start_mult)     state_n = MUL;
        else if (start_div) state_n = DIV;
      end
      MUL, DIV: if (cnt == CW'(1)) state_n = FIX;
      FIX:      state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    a_neg    = mult_sign & srca[WIDTH-1];
    b_neg    = mult_sign & srcb[WIDTH-1];
    a_abs    = a_neg ? -srca : srca;
    b_abs    = b_neg ? -srcb : srcb;
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? a_reg : '0)};
    // Remainder shifted left with the next dividend bit; WIDTH+1 bits avoid overflow.
    trial    = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    diff     = trial - {1'b0, b_reg};
    prod_neg = -prod;
    rem      = prod[2*WIDTH-1:WIDTH];
    quo      = prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      prod     <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      is_mul   <= 1'b0;
      res_neg  <= 1'b0;
      dvd_neg  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mult || start_div) begin
            cnt      <= CW'(WIDTH);
            b_reg    <= b_abs;
            is_mul   <= start_mult;
            res_neg  <= a_neg ^ b_neg;
            dvd_neg  <= a_neg;
            div_zero <= ~start_mult & (srcb == '0);
            if (start_mult) begin
              a_reg <= a_abs;
              prod  <= {{WIDTH{1'b0}}, b_abs};
            end else begin
              // Raw dividend is kept for the divide-by-zero HI result.
              a_reg <= srca;
              prod  <= {{WIDTH{1'b0}}, a_abs};
            end
          end else begin
            if (mthi) hi <= srca;
            if (mtlo) lo <= srca;
          end
        end
        MUL: begin
          prod <= {mul_sum, prod[WIDTH-1:1]};
          cnt  <= cnt - 1'b1;
        end
        DIV: begin
          if (!diff[WIDTH]) prod <= {diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
          else              prod <= {trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          if (is_mul) begin
            {hi, lo} <= res_neg ? prod_neg : prod;
          end else if (div_zero) begin
            hi <= a_reg;
            lo <= '1;
          end else begin
            hi <= dvd_neg ? -rem : rem;
            lo <= res_neg ? -quo : quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus hand-written corner sequences.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_mult, start_div, mult_sign, mthi, mtlo;
  logic [W-1:0] srca, srcb;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] model_hi, model_lo;

  typedef struct {
    logic         sm;
    logic         sd;
    logic         sg;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
  } vec_t;

  vec_t vecs[13];

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .mult_sign(mult_sign), .srca(srca), .srcb(srcb), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // inj_kind: 1 = pulse start_div, 2 = pulse mthi with 0xAAAA5555, at sample inj_cycle.
  task automatic run_op(input string name, input logic sm, input logic sd, input logic sg,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input int inj_cycle, input int inj_kind);
    int bad;
    bad = 0;
    srca = a; srcb = b; mult_sign = sg; start_mult = sm; start_div = sd;
    @(posedge clk);
    #1 start_mult = 1'b0; start_div = 1'b0;
    for (int j = 0; j <= W; j++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0 || hi !== model_hi || lo !== model_lo) bad++;
      if (j == inj_cycle + 1) begin
        start_div = 1'b0; mthi = 1'b0;
      end
      if (j == inj_cycle) begin
        if (inj_kind == 1) begin
          start_div = 1'b1; srcb = '0;
        end
        if (inj_kind == 2) begin
          mthi = 1'b1; srca = 32'hAAAA5555;
        end
      end
    end
    start_div = 1'b0; mthi = 1'b0;
    check({name, "_busy_window"}, 64'(bad), 64'd0);
    @(negedge clk);
    check({name, "_done"}, {62'd0, done, busy}, 64'b10);
    check({name, "_hi"}, 64'(hi), 64'(ehi));
    check({name, "_lo"}, 64'(lo), 64'(elo));
    model_hi = ehi; model_lo = elo;
  endtask

  initial begin
    vecs[0]  = '{1, 0, 1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{0, 1, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{0, 1, 0, 32'd7,        32'd2,        32'd1,        32'd3};
    vecs[4]  = '{0, 1, 1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[5]  = '{0, 1, 0, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
    vecs[6]  = '{0, 1, 1, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[7]  = '{1, 1, 1, 32'd6,        32'd7,        32'd0,        32'h0000002A};
    vecs[8]  = '{1, 0, 1, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    vecs[9]  = '{1, 0, 1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[10] = '{0, 1, 0, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF};
    vecs[11] = '{0, 1, 1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[12] = '{1, 0, 0, 32'h12345678, 32'h10,       32'd1,        32'h23456780};

    reset = 1'b1; start_mult = 0; start_div = 0; mult_sign = 0; mthi = 0; mtlo = 0;
    srca = '0; srcb = '0;
    model_hi = '0; model_lo = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {busy, done, hi, lo}, 66'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), vecs[i].sm, vecs[i].sd, vecs[i].sg, vecs[i].a,
             vecs[i].b, vecs[i].ehi, vecs[i].elo, -1, 0);

    run_op("div_ignored", 1, 0, 1, 32'd5, 32'd7, 32'd0, 32'd35, 5, 1);
    run_op("mthi_busy", 1, 0, 0, 32'd9, 32'd9, 32'd0, 32'd81, 3, 2);

    // mthi alone, then mthi+mtlo together, while idle
    @(negedge clk);
    check("idle_done_low", 64'(done), 64'd0);
    srca = 32'hAAAA5555; mthi = 1'b1;
    @(posedge clk);
    #1 mthi = 1'b0;
    @(negedge clk);
    check("mthi_idle_hi", 64'(hi), 64'hAAAA5555);
    check("mthi_idle_lo", 64'(lo), 64'(model_lo));
    srca = 32'h0F0F0F0F; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk);
    #1 mthi = 1'b0; mtlo = 1'b0;
    @(negedge clk);
    check("mthi_mtlo_both", {hi, lo}, {32'h0F0F0F0F, 32'h0F0F0F0F});
    model_hi = 32'h0F0F0F0F; model_lo = 32'h0F0F0F0F;

    // asynchronous reset in the middle of a divide
    srca = 32'd100; srcb = 32'd3; mult_sign = 1'b0; start_div = 1'b1;
    @(posedge clk);
    #1 start_div = 1'b0;
    repeat (10) @(negedge clk);
    check("div_in_flight", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1 check("async_reset", {busy, done, hi, lo}, 66'd0);
    @(negedge clk);
    reset = 1'b0;
    model_hi = '0; model_lo = '0;
    run_op("after_reset", 1, 0, 0, 32'd3, 32'd4, 32'd0, 32'd12, -1, 0);
    @(negedge clk);
    check("final_done_low", {62'd0, done, busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
